// File: rtl/sprite_pixel_sequencer.sv
// Sprite pixel sequencer: hit-tests the current pixel against Pacman and two ghosts,
// drives the sprite ROM, maps ROM codes to RGB and steps animation frames from vsync.
module sprite_pixel_sequencer #(
   parameter int SPR_SIZE        = 16,
   parameter int FRAMES_PER_STEP = 4,
   parameter int GHOST_PERIOD    = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       blank,
   input  logic [9:0] pac_x,
   input  logic [9:0] pac_y,
   input  logic [9:0] g1_x,
   input  logic [9:0] g1_y,
   input  logic [9:0] g2_x,
   input  logic [9:0] g2_y,
   input  logic       pac_moving,
   output logic [9:0] rom_x,
   output logic [9:0] rom_y,
   output logic       isPacman,
   output logic       isGhost1,
   output logic       isGhost2,
   output logic [1:0] pac_move,
   output logic       ghost_frame,
   input  logic [1:0] rom_data,
   output logic [7:0] Red,
   output logic [7:0] Green,
   output logic [7:0] Blue
);

   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int GW = (GHOST_PERIOD > 1) ? $clog2(GHOST_PERIOD) : 1;

   typedef enum logic [1:0] {P0, P1, P2, P3} mouth_t;

   mouth_t          r_state, w_state_nxt;
   logic [FW-1:0]   r_frame_cnt, w_frame_cnt_nxt;
   logic [GW-1:0]   r_ghost_cnt;
   logic            r_ghost_frame;
   logic            r_fclk_d;
   logic            w_tick;

   logic            w_hit_pac, w_hit_g1, w_hit_g2;
   logic            w_sel_pac, w_sel_g1, w_sel_g2;
   logic [9:0]      w_romx, w_romy;

   logic [9:0]      r_romx_p1, r_romy_p1;
   logic            r_selp_p1, r_sel1_p1, r_sel2_p1;
   logic            r_vld_p1;
   logic [23:0]     r_rgb_p2;

   // Widened to 11 bits so a sprite near the right/bottom edge cannot wrap into column 0.
   function automatic logic hit_f(input logic [9:0] d, input logic [9:0] o);
      logic [10:0] lo;
      logic [10:0] hi;
      lo = {1'b0, o};
      hi = lo + 11'(SPR_SIZE);
      return ({1'b0, d} >= lo) && ({1'b0, d} < hi);
   endfunction

   function automatic logic [23:0] colour_f(input logic [1:0] code, input logic sp,
                                            input logic s1, input logic s2, input logic vld);
      logic [23:0] c;
      c = 24'h000000;
      if (vld && (sp || s1 || s2)) begin
         case (code)
            2'd1:    c = sp ? 24'hFFFF00 : (s1 ? 24'hFF0000 : 24'hFFB8FF);
            2'd2:    c = 24'hFFFFFF;
            2'd3:    c = 24'h2121DE;
            default: c = 24'h000000;
         endcase
      end
      return c;
   endfunction

   assign w_tick = frame_clk & ~r_fclk_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fclk_d      <= 1'b0;
         r_state       <= P0;
         r_frame_cnt   <= '0;
         r_ghost_cnt   <= '0;
         r_ghost_frame <= 1'b0;
      end else begin
         r_fclk_d    <= frame_clk;
         r_state     <= w_state_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         if (w_tick) begin
            if (r_ghost_cnt == GW'(GHOST_PERIOD - 1)) begin
               r_ghost_cnt   <= '0;
               r_ghost_frame <= ~r_ghost_frame;
            end else begin
               r_ghost_cnt <= r_ghost_cnt + GW'(1);
            end
         end
      end
   end

   // Mouth only advances on ticks while moving; otherwise phase and count freeze.
   always_comb begin
      w_state_nxt     = r_state;
      w_frame_cnt_nxt = r_frame_cnt;
      pac_move        = 2'd0;
      if (w_tick && pac_moving) begin
         if (r_frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
            w_frame_cnt_nxt = '0;
            case (r_state)
               P0:      w_state_nxt = P1;
               P1:      w_state_nxt = P2;
               P2:      w_state_nxt = P3;
               default: w_state_nxt = P0;
            endcase
         end else begin
            w_frame_cnt_nxt = r_frame_cnt + FW'(1);
         end
      end
      case (r_state)
         P1, P3:  pac_move = 2'd1;
         P2:      pac_move = 2'd2;
         default: pac_move = 2'd0;
      endcase
   end

   assign ghost_frame = r_ghost_frame;

   // Stage 0: hit test and priority select
   always_comb begin
      w_hit_pac = hit_f(DrawX, pac_x) && hit_f(DrawY, pac_y);
      w_hit_g1  = hit_f(DrawX, g1_x)  && hit_f(DrawY, g1_y);
      w_hit_g2  = hit_f(DrawX, g2_x)  && hit_f(DrawY, g2_y);
      w_sel_pac = w_hit_pac;
      w_sel_g1  = ~w_hit_pac & w_hit_g1;
      w_sel_g2  = ~w_hit_pac & ~w_hit_g1 & w_hit_g2;
      w_romx    = 10'd0;
      w_romy    = 10'd0;
      if (w_sel_pac) begin
         w_romx = DrawX - pac_x;
         w_romy = DrawY - pac_y;
      end else if (w_sel_g1) begin
         w_romx = DrawX - g1_x;
         w_romy = DrawY - g1_y;
      end else if (w_sel_g2) begin
         w_romx = DrawX - g2_x;
         w_romy = DrawY - g2_y;
      end
   end

   // Stage 1: ROM address and select
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_romx_p1 <= 10'd0;
         r_romy_p1 <= 10'd0;
         r_selp_p1 <= 1'b0;
         r_sel1_p1 <= 1'b0;
         r_sel2_p1 <= 1'b0;
         r_vld_p1  <= 1'b0;
      end else begin
         r_romx_p1 <= w_romx;
         r_romy_p1 <= w_romy;
         r_selp_p1 <= w_sel_pac;
         r_sel1_p1 <= w_sel_g1;
         r_sel2_p1 <= w_sel_g2;
         r_vld_p1  <= blank;
      end
   end

   assign rom_x    = r_romx_p1;
   assign rom_y    = r_romy_p1;
   assign isPacman = r_selp_p1;
   assign isGhost1 = r_sel1_p1;
   assign isGhost2 = r_sel2_p1;

   // Stage 2: colour lookup of the ROM code
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_rgb_p2 <= 24'h000000;
      end else begin
         r_rgb_p2 <= colour_f(rom_data, r_selp_p1, r_sel1_p1, r_sel2_p1, r_vld_p1);
      end
   end

   assign Red   = r_rgb_p2[23:16];
   assign Green = r_rgb_p2[15:8];
   assign Blue  = r_rgb_p2[7:0];

endmodule
